// File: rtl/obi_rand_pkg.sv
// Shared types and helpers for the randomized OBI responder.
package obi_rand_pkg;

   localparam int OBI_ADDR_W        = 32;
   localparam int OBI_DATA_W        = 32;
   localparam int DEFAULT_STALL_MAX = 4;

   // Request fields that must stay stable while a request waits for its grant.
   typedef struct packed {
      logic [OBI_ADDR_W-1:0]   addr;
      logic                    we;
      logic [OBI_DATA_W/8-1:0] be;
      logic [OBI_DATA_W-1:0]   wdata;
   } obi_req_t;

   // Width of a counter that must hold 0..max_pnd inclusive.
   function automatic int pnd_w(input int max_pnd);
      return (max_pnd < 1) ? 1 : $clog2(max_pnd + 1);
   endfunction

endpackage

// File: rtl/obi_rsp_fifo.sv
// Small in-order FIFO holding per-transaction metadata between grant and response.
// A push and a pop in the same cycle are accepted even when full or non-empty,
// leaving occupancy unchanged.
module obi_rsp_fifo #(
   parameter int DEPTH = 2,
   parameter int W     = 1
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         push_i,
   input  logic         pop_i,
   input  logic [W-1:0] data_i,
   output logic [W-1:0] head_o,
   output logic         empty_o,
   output logic         full_o
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic          do_push;
   logic          do_pop;

   // Pointers wrap at DEPTH, which need not be a power of two.
   function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign empty_o = (count == '0);
   assign full_o  = (count == CW'(DEPTH));
   assign head_o  = mem[rd_ptr];
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= ptr_next(wr_ptr);
         if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
         if (do_push && !do_pop)      count <= count + 1'b1;
         else if (do_pop && !do_push) count <= count - 1'b1;
      end
   end

   // Storage is written on push; contents are don't-care while empty.
   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr] <= data_i;
   end

endmodule

// File: rtl/obi_rand_responder.sv
// OBI slave model for formal wrappers: grant and response timing come from free
// random stimulus, but are shaped so the core always sees a legal, live slave.
// Core-side protocol violations on an ungranted request latch proto_err_o.
//
// Handshake: a request transfers in a cycle with req_i && gnt_o; its response
// transfers in a later cycle with rvalid_o, in grant order, with no back-pressure.
module obi_rand_responder
   import obi_rand_pkg::*;
#(
   parameter int MAX_PND   = 2,
   parameter int STALL_MAX = DEFAULT_STALL_MAX,
   parameter int DATA_W    = 32,
   parameter int ADDR_W    = 32
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       req_i,
   input  logic [ADDR_W-1:0]          addr_i,
   input  logic                       we_i,
   input  logic [DATA_W/8-1:0]        be_i,
   input  logic [DATA_W-1:0]          wdata_i,
   output logic                       gnt_o,
   output logic                       rvalid_o,
   output logic [DATA_W-1:0]          rdata_o,
   input  logic                       rand_gnt_i,
   input  logic                       rand_rvalid_i,
   input  logic [DATA_W-1:0]          rand_rdata_i,
   output logic [pnd_w(MAX_PND)-1:0]  pnd_cnt_o,
   output logic                       proto_err_o
);

   localparam int               PND_W       = pnd_w(MAX_PND);
   localparam logic [PND_W-1:0] PND_LIMIT   = PND_W'(MAX_PND);
   localparam int               SW          = (STALL_MAX < 1) ? 1 : $clog2(STALL_MAX + 1);
   localparam logic [SW-1:0]    STALL_LIMIT = SW'(STALL_MAX);
   localparam bit               FORCE_EN    = (STALL_MAX != 0);

   // Local view of the request fields at this instance's widths.
   typedef struct packed {
      logic [ADDR_W-1:0]   addr;
      logic                we;
      logic [DATA_W/8-1:0] be;
      logic [DATA_W-1:0]   wdata;
   } req_t;

   logic [PND_W-1:0] pnd_cnt;
   logic [SW-1:0]    gnt_stall;
   logic [SW-1:0]    rv_stall;
   logic             gnt_force;
   logic             rv_force;
   logic             fifo_empty;
   logic             fifo_full;
   logic             head_we;
   logic             hold_vld;
   req_t             hold_req;
   req_t             cur_req;
   logic             proto_err;

   assign cur_req   = {addr_i, we_i, be_i, wdata_i};
   assign gnt_force = FORCE_EN && (gnt_stall == STALL_LIMIT);
   assign rv_force  = FORCE_EN && (rv_stall == STALL_LIMIT);

   // Grant never looks at this cycle's response, so a full count blocks it
   // even when an entry is leaving. Response only ever sees registered count,
   // which rules out a same-cycle response to a fresh grant.
   assign gnt_o    = req_i && (pnd_cnt < PND_LIMIT) && !fifo_full
                     && (rand_gnt_i || gnt_force);
   assign rvalid_o = (pnd_cnt != '0) && !fifo_empty && (rand_rvalid_i || rv_force);
   assign rdata_o  = (rvalid_o && !head_we) ? rand_rdata_i : '0;

   assign pnd_cnt_o   = pnd_cnt;
   assign proto_err_o = proto_err;

   obi_rsp_fifo #(
      .DEPTH (MAX_PND),
      .W     (1)
   ) u_rsp_fifo (
      .clock   (clock),
      .reset   (reset),
      .push_i  (gnt_o),
      .pop_i   (rvalid_o),
      .data_i  (we_i),
      .head_o  (head_we),
      .empty_o (fifo_empty),
      .full_o  (fifo_full)
   );

   // Outstanding count: up on grant, down on response, unchanged on both.
   always_ff @(posedge clock) begin
      if (reset) begin
         pnd_cnt <= '0;
      end else if (gnt_o && !rvalid_o) begin
         pnd_cnt <= pnd_cnt + 1'b1;
      end else if (rvalid_o && !gnt_o) begin
         pnd_cnt <= pnd_cnt - 1'b1;
      end
   end

   // Saturating stall counters that force gnt/rvalid once they reach the limit.
   always_ff @(posedge clock) begin
      if (reset) begin
         gnt_stall <= '0;
         rv_stall  <= '0;
      end else begin
         if (!req_i || gnt_o)              gnt_stall <= '0;
         else if (gnt_stall != STALL_LIMIT) gnt_stall <= gnt_stall + 1'b1;

         if ((pnd_cnt == '0) || rvalid_o)  rv_stall <= '0;
         else if (rv_stall != STALL_LIMIT) rv_stall <= rv_stall + 1'b1;
      end
   end

   // Capture a waiting request and flag it if it is withdrawn or altered.
   always_ff @(posedge clock) begin
      if (reset) begin
         hold_vld  <= 1'b0;
         hold_req  <= '0;
         proto_err <= 1'b0;
      end else if (hold_vld) begin
         if (!req_i || (cur_req != hold_req)) proto_err <= 1'b1;
         if (!req_i || gnt_o)                 hold_vld  <= 1'b0;
      end else if (req_i && !gnt_o) begin
         hold_vld <= 1'b1;
         hold_req <= cur_req;
      end
   end

endmodule

// File: tb/tb_obi_rand_responder.sv
// Directed bench for obi_rand_responder (MAX_PND=2, STALL_MAX=4): a cycle table
// for the handshake cases plus hand sequences for stall forcing, protocol error
// and reset.
module tb_obi_rand_responder;

   logic        clock;
   logic        reset;
   logic        req_i;
   logic [31:0] addr_i;
   logic        we_i;
   logic [3:0]  be_i;
   logic [31:0] wdata_i;
   logic        gnt_o;
   logic        rvalid_o;
   logic [31:0] rdata_o;
   logic        rand_gnt_i;
   logic        rand_rvalid_i;
   logic [31:0] rand_rdata_i;
   logic [1:0]  pnd_cnt_o;
   logic        proto_err_o;

   int checks = 0;
   int errors = 0;

   obi_rand_responder #(
      .MAX_PND   (2),
      .STALL_MAX (4),
      .DATA_W    (32),
      .ADDR_W    (32)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .req_i         (req_i),
      .addr_i        (addr_i),
      .we_i          (we_i),
      .be_i          (be_i),
      .wdata_i       (wdata_i),
      .gnt_o         (gnt_o),
      .rvalid_o      (rvalid_o),
      .rdata_o       (rdata_o),
      .rand_gnt_i    (rand_gnt_i),
      .rand_rvalid_i (rand_rvalid_i),
      .rand_rdata_i  (rand_rdata_i),
      .pnd_cnt_o     (pnd_cnt_o),
      .proto_err_o   (proto_err_o)
   );

   // Clock: period 10.
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   typedef struct {
      logic        req;
      logic        we;
      logic [31:0] addr;
      logic        rg;
      logic        rv;
      logic [31:0] rd;
      logic        e_gnt;
      logic        e_rv;
      logic [31:0] e_rdata;
      logic [1:0]  e_pnd;
   } vec_t;

   vec_t vq[$];

   task automatic add(input logic req, input logic we, input logic [31:0] addr,
                      input logic rg, input logic rv, input logic [31:0] rd,
                      input logic e_gnt, input logic e_rv, input logic [31:0] e_rdata,
                      input logic [1:0] e_pnd);
      vec_t v;
      v.req = req; v.we = we; v.addr = addr; v.rg = rg; v.rv = rv; v.rd = rd;
      v.e_gnt = e_gnt; v.e_rv = e_rv; v.e_rdata = e_rdata; v.e_pnd = e_pnd;
      vq.push_back(v);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic req, input logic we, input logic [31:0] addr,
                        input logic rg, input logic rv, input logic [31:0] rd);
      req_i = req; we_i = we; addr_i = addr;
      rand_gnt_i = rg; rand_rvalid_i = rv; rand_rdata_i = rd;
   endtask

   // Advance to just after the next active edge.
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   initial begin
      reset = 1'b1;
      be_i = 4'hF;
      wdata_i = 32'hCAFE_0000;
      drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFF);
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;

      // Reset state: idle outputs even with random response asserted.
      @(negedge clock);
      chk("rst_pnd", 32'(pnd_cnt_o), 32'd0);
      chk("rst_err", 32'(proto_err_o), 32'd0);
      chk("rst_gnt", 32'(gnt_o), 32'd0);
      chk("rst_rvalid", 32'(rvalid_o), 32'd0);
      chk("rst_rdata", rdata_o, 32'd0);
      step();

      //  req we addr       rg rv rd             gnt rv rdata          pnd
      // Read handshake
      add(1, 0, 32'h10,  1, 0, 32'h0,         1, 0, 32'h0,         2'd0);
      add(0, 0, 32'h0,   0, 0, 32'h0,         0, 0, 32'h0,         2'd1);
      add(0, 0, 32'h0,   0, 1, 32'hDEADBEEF,  0, 1, 32'hDEADBEEF,  2'd1);
      add(0, 0, 32'h0,   0, 1, 32'h1111,      0, 0, 32'h0,         2'd0);
      // Full limit: two grants, blocked while full, blocked in the pop cycle
      add(1, 0, 32'h20,  1, 0, 32'h0,         1, 0, 32'h0,         2'd0);
      add(1, 0, 32'h24,  1, 0, 32'h0,         1, 0, 32'h0,         2'd1);
      add(1, 0, 32'h28,  1, 0, 32'h0,         0, 0, 32'h0,         2'd2);
      add(1, 0, 32'h28,  1, 1, 32'h55,        0, 1, 32'h55,        2'd2);
      add(1, 0, 32'h28,  1, 0, 32'h0,         1, 0, 32'h0,         2'd1);
      add(0, 0, 32'h0,   0, 1, 32'hA,         0, 1, 32'hA,         2'd2);
      add(0, 0, 32'h0,   0, 1, 32'hB,         0, 1, 32'hB,         2'd1);
      // Write masking: write then read
      add(1, 1, 32'h30,  1, 0, 32'h0,         1, 0, 32'h0,         2'd0);
      add(1, 0, 32'h34,  1, 0, 32'h0,         1, 0, 32'h0,         2'd1);
      add(0, 0, 32'h0,   0, 1, 32'h12345678,  0, 1, 32'h0,         2'd2);
      add(0, 0, 32'h0,   0, 1, 32'h12345678,  0, 1, 32'h12345678,  2'd1);
      add(0, 0, 32'h0,   0, 0, 32'h0,         0, 0, 32'h0,         2'd0);
      // Simultaneous grant and response with a non-empty queue
      add(1, 0, 32'h40,  1, 0, 32'h0,         1, 0, 32'h0,         2'd0);
      add(1, 1, 32'h44,  1, 1, 32'h77,        1, 1, 32'h77,        2'd1);
      add(0, 0, 32'h0,   0, 1, 32'h99,        0, 1, 32'h0,         2'd1);
      add(0, 0, 32'h0,   0, 0, 32'h0,         0, 0, 32'h0,         2'd0);

      foreach (vq[i]) begin
         drive(vq[i].req, vq[i].we, vq[i].addr, vq[i].rg, vq[i].rv, vq[i].rd);
         @(negedge clock);
         chk($sformatf("v%0d_gnt", i), 32'(gnt_o), 32'(vq[i].e_gnt));
         chk($sformatf("v%0d_rvalid", i), 32'(rvalid_o), 32'(vq[i].e_rv));
         chk($sformatf("v%0d_rdata", i), rdata_o, vq[i].e_rdata);
         chk($sformatf("v%0d_pnd", i), 32'(pnd_cnt_o), 32'(vq[i].e_pnd));
         chk($sformatf("v%0d_err", i), 32'(proto_err_o), 32'd0);
         step();
      end

      // Liveness: grant forced on the 5th request cycle.
      drive(1, 0, 32'h200, 0, 0, 32'h0);
      for (int k = 1; k <= 5; k++) begin
         @(negedge clock);
         chk($sformatf("live_gnt_c%0d", k), 32'(gnt_o), (k == 5) ? 32'd1 : 32'd0);
         step();
      end
      // Response forced after 4 stalled pending cycles.
      drive(0, 0, 32'h0, 0, 0, 32'hBEEF0001);
      for (int k = 1; k <= 5; k++) begin
         @(negedge clock);
         chk($sformatf("live_pnd_c%0d", k), 32'(pnd_cnt_o), 32'd1);
         chk($sformatf("live_rv_c%0d", k), 32'(rvalid_o), (k == 5) ? 32'd1 : 32'd0);
         if (k == 5) chk("live_rdata", rdata_o, 32'hBEEF0001);
         step();
      end
      @(negedge clock);
      chk("live_pnd_end", 32'(pnd_cnt_o), 32'd0);
      step();

      // Protocol error: address changes before grant.
      drive(1, 0, 32'h100, 0, 0, 32'h0);
      @(negedge clock);
      chk("perr_c1_gnt", 32'(gnt_o), 32'd0);
      chk("perr_c1_err", 32'(proto_err_o), 32'd0);
      step();
      drive(1, 0, 32'h104, 0, 0, 32'h0);
      @(negedge clock);
      chk("perr_c2_err", 32'(proto_err_o), 32'd0);
      step();
      drive(0, 0, 32'h0, 0, 0, 32'h0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clock);
         chk($sformatf("perr_sticky%0d", k), 32'(proto_err_o), 32'd1);
         step();
      end

      // Reset mid-operation with two outstanding.
      drive(1, 0, 32'h300, 1, 0, 32'h0);
      @(negedge clock);
      chk("mid_gnt0", 32'(gnt_o), 32'd1);
      step();
      drive(1, 0, 32'h304, 1, 0, 32'h0);
      @(negedge clock);
      chk("mid_gnt1", 32'(gnt_o), 32'd1);
      step();
      drive(0, 0, 32'h0, 0, 1, 32'h5A5A5A5A);
      @(negedge clock);
      chk("mid_pnd2", 32'(pnd_cnt_o), 32'd2);
      chk("mid_err", 32'(proto_err_o), 32'd1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      for (int k = 0; k < 2; k++) begin
         @(negedge clock);
         chk($sformatf("post_rst_pnd%0d", k), 32'(pnd_cnt_o), 32'd0);
         chk($sformatf("post_rst_rv%0d", k), 32'(rvalid_o), 32'd0);
         chk($sformatf("post_rst_rdata%0d", k), rdata_o, 32'd0);
         chk($sformatf("post_rst_err%0d", k), 32'(proto_err_o), 32'd0);
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/obi_rand_responder.md
Name: obi_rand_responder

Overview:
- Formal-friendly OBI slave model that drives the core's instruction or data memory port from free-running random stimulus bits.
- One instance per port sits directly upstream of the core inside the formal wrapper and replaces bare random gnt/rvalid/rdata.
- Protocol legality is enforced by construction: bounded outstanding transactions, in-order responses, bounded stalls for liveness.
- Flags core-side OBI violations on a sticky error output.

Parameters:
- MAX_PND, 2, maximum outstanding granted-but-unanswered transactions (1..7).
- STALL_MAX, 4, cycles after which a stalled gnt or rvalid is forced high (0 disables forcing).
- DATA_W, 32, data width.
- ADDR_W, 32, address width.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req_i  in  1  core request
- addr_i  in  ADDR_W  core address
- we_i  in  1  core write enable
- be_i  in  DATA_W/8  core byte enables
- wdata_i  in  DATA_W  core write data
- gnt_o  out  1  grant to core
- rvalid_o  out  1  response valid to core
- rdata_o  out  DATA_W  response data
- rand_gnt_i  in  1  random grant stimulus
- rand_rvalid_i  in  1  random response stimulus
- rand_rdata_i  in  DATA_W  random read data
- pnd_cnt_o  out  $clog2(MAX_PND+1)  outstanding transaction count
- proto_err_o  out  1  sticky core-side protocol violation

Behaviour:
- Reset (synchronous, active-high): pnd_cnt=0, FIFO empty, stall counters=0, proto_err_o=0.
- gnt_o and rvalid_o are combinational from state and stimulus. Both read 0 in any cycle with pnd_cnt=0 and req_i=0.
- gnt_o = req_i && (pnd_cnt < MAX_PND) && (rand_gnt_i || gnt_stall == STALL_MAX). A grant is never given when the count is full, even if a response pops in the same cycle.
- rvalid_o = (pnd_cnt != 0) && (rand_rvalid_i || rv_stall == STALL_MAX). Earliest response is the cycle after the grant: zero-cycle combinational response is forbidden.
- pnd_cnt update:
  - +1 on gnt only.
  - -1 on rvalid only.
  - Unchanged when both occur.
  - Never wraps.
- Response FIFO:
  - Depth MAX_PND, in-order. Entry = {we}, pushed on gnt, popped on rvalid.
  - Simultaneous push/pop with a non-empty FIFO is legal; occupancy is unchanged.
- rdata_o = rand_rdata_i when rvalid_o and the head entry is a read; 0 when the head entry is a write or rvalid_o=0.
- gnt_stall counts cycles with req_i && !gnt_o, saturating at STALL_MAX. It clears on gnt_o or !req_i.
- rv_stall counts cycles with pnd_cnt!=0 && !rvalid_o, saturating at STALL_MAX. It clears on rvalid_o or when pnd_cnt=0.
- Request hold register captures {addr, we, be, wdata} on the first cycle of req_i && !gnt_o. It is valid while that request remains ungranted.
- proto_err_o is set next cycle and held until reset when either:
  - A held request drops req_i before gnt.
  - A held request changes any captured field before gnt.
- Reset mid-transaction: outstanding transactions are discarded and no rvalid is produced for them.

Decomposition:
- Shared package obi_rand_pkg holds:
  - obi_req_t struct {addr, we, be, wdata}.
  - pnd_cnt width function.
  - STALL_MAX default constant.
- Natural sub-module: obi_rsp_fifo, a synchronous FIFO of depth MAX_PND with push/pop/empty/full and a head output. It is reused for per-transaction metadata.

Test Plan:
- Read handshake: MAX_PND=2, req_i=1 with rand_gnt_i=1 at cycle 1, rand_rvalid_i=1 at cycle 3, rand_rdata_i=0xDEADBEEF -> gnt_o=1 at cycle 1; pnd_cnt_o=1 at cycles 2–3; rvalid_o=1 with rdata_o=0xDEADBEEF at cycle 3; pnd_cnt_o=0 at cycle 4.
- Full limit: req_i held high, rand_gnt_i=1, rand_rvalid_i=0 -> exactly 2 grants, then gnt_o=0 while pnd_cnt_o=2. In the first rvalid cycle gnt_o stays 0; gnt resumes the following cycle.
- Write rdata masking: grant a write, then a read, then rand_rvalid_i=1 for two cycles with rand_rdata_i=0x12345678 -> rdata_o=0 on the first response and 0x12345678 on the second.
- Liveness forcing: STALL_MAX=4, req_i=1, rand_gnt_i=0 -> gnt_o=1 exactly on the 5th request cycle. With rand_rvalid_i=0 after that, rvalid_o is forced after 4 stalled pending cycles.
- Protocol error: req_i=1 with addr 0x100, rand_gnt_i=0, then addr changes to 0x104 before grant -> proto_err_o=1 next cycle, stays 1, and clears only on reset.
- Reset mid-operation: pnd_cnt_o=2, assert reset one cycle -> pnd_cnt_o=0, rvalid_o=0 even with rand_rvalid_i=1, and proto_err_o=0 afterwards.
